ring_osc_meas_ctrl: RTL

Synchronous sequencer for a gated self-timed buffer ring (inverter plus buffer chain). It enables the ring, waits a settle time, and counts rising edges of the asynchronous ring tap over a programmable window of clock cycles. It then disables the ring, lets it quiesce, and reports the edge count via a start/done handshake. It sits between the test/config logic and the ring macro, and is the only agent that drives the ring enable.

---
 rtl/ring_osc_meas_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl
//
// Sequencer for a gated self-timed buffer ring. A measurement runs through four phases:
// enable the ring and let it settle, count rising edges of the ring tap over a window of clk
// cycles, disable the ring and let it quiesce, then report the count with a one-cycle done.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   start_i     request a measurement (accepted only in idle)
//   abort_i     cancel a measurement during settle/measure
//   window_i    measurement length in clk cycles, captured on accepted start
//   ring_out_i  asynchronous ring tap, synchronized internally
//   ring_en_o   registered ring enable (0 forces the ring to rest)
//   busy_o      high from accepted start until done pulse or end of abort drain
//   done_o      one-cycle pulse, count_o/overflow_o valid
//   count_o     saturating rising-edge count, held until next accepted start
//   overflow_o  an edge arrived while count_o was saturated
module ring_osc_meas_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned DRAIN_CYC   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic             ring_out_i,
    output logic             ring_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDrain,
        StReport
    } state_e;

    // One down-counter times every phase, so it must hold the window and both fixed delays.
    localparam int unsigned AuxMax = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
    localparam int unsigned AuxW   = $clog2(AuxMax + 1);
    localparam int unsigned TmrW   = (WIN_W > AuxW) ? WIN_W : AuxW;

    localparam logic [TmrW-1:0] SettleLoad = TmrW'(SETTLE_CYC - 1);
    localparam logic [TmrW-1:0] DrainLoad  = TmrW'(DRAIN_CYC - 1);

    state_e           state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             ring_en_q, busy_q, done_q;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    // Only sync_q[0] can go metastable; everything downstream reads the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ring_out_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // The detector runs in every state; only measure cycles consume a detection.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        win_d      = win_q;
        aborted_d  = aborted_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StSettle;
                    tmr_d      = SettleLoad;
                    win_d      = window_i;
                    aborted_d  = 1'b0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            StSettle: begin
                if (abort_i) begin
                    state_d   = StDrain;
                    tmr_d     = DrainLoad;
                    aborted_d = 1'b1;
                end else if (tmr_q == '0) begin
                    if (win_q == '0) begin
                        state_d = StDrain;
                        tmr_d   = DrainLoad;
                    end else begin
                        state_d = StMeasure;
                        tmr_d   = TmrW'(win_q) - 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StMeasure: begin
                if (rise) begin
                    if (&count_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (abort_i) begin
                    state_d   = StDrain;
                    tmr_d     = DrainLoad;
                    aborted_d = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = StDrain;
                    tmr_d   = DrainLoad;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StDrain: begin
                if (tmr_q == '0) begin
                    // An aborted run returns silently; a full run reports.
                    state_d = aborted_q ? StIdle : StReport;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            win_q      <= '0;
            aborted_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ring_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            win_q      <= win_d;
            aborted_q  <= aborted_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            // Outputs are registered decodes of the next state so they never glitch.
            ring_en_q  <= (state_d == StSettle) || (state_d == StMeasure);
            busy_q     <= (state_d == StSettle) || (state_d == StMeasure) ||
                          (state_d == StDrain);
            done_q     <= (state_d == StReport);
        end
    end

    assign ring_en_o  = ring_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
